// File: rtl/instr_sequencer.sv
// Two-phase (FETCH/EXEC) instruction sequencer driving an external ALU and
// register file from a 9-bit instruction stream read combinationally at pc.
module instr_sequencer #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic [8:0]      instr,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      alu_op,
    output logic            alu_flag_in,
    input  logic            alu_flag,
    output logic [3:0]      rf_raddr_b,
    output logic            rf_we,
    output logic [3:0]      rf_waddr,
    output logic [1:0]      rf_wsel,
    output logic [7:0]      imm,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [8:0]      ir;
    logic [8:0]      ir_next;
    logic            flag_q;
    logic            flag_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] br_off;

    // Branch offset is a signed 7-bit field, sign-extended to the pc width.
    assign br_off      = PC_W'($signed(ir[6:0]));
    assign busy        = (state != IDLE);
    assign alu_flag_in = flag_q;

    // State, pc, instruction and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= '0;
            ir     <= '0;
            flag_q <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            ir     <= ir_next;
            flag_q <= flag_next;
        end
    end

    // Next-state sequencing and instruction decode during EXEC.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        flag_next  = flag_q;
        alu_op     = '0;
        rf_raddr_b = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wsel    = '0;
        imm        = '0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_next    = start_addr;
                    flag_next  = 1'b0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                ir_next    = instr;
                state_next = EXEC;
            end
            EXEC: begin
                state_next = FETCH;
                pc_next    = pc + PC_W'(1);
                if (!ir[8]) begin
                    // ALU-type: operand A is r0, result returns to r0.
                    alu_op     = ir[7:4];
                    rf_raddr_b = ir[3:0];
                    rf_we      = !((ir[7:4] == 4'd5) || (ir[7:4] == 4'd8));
                    flag_next  = alu_flag;
                end else if (!ir[7]) begin
                    if (flag_q) begin
                        pc_next = pc + br_off;
                    end
                end else begin
                    case (ir[6:5])
                        2'b00: begin
                            rf_we   = 1'b1;
                            rf_wsel = 2'd1;
                            imm     = {3'b000, ir[4:0]};
                        end
                        2'b01: begin
                            rf_we    = 1'b1;
                            rf_waddr = ir[3:0];
                            rf_wsel  = 2'd2;
                        end
                        2'b10: begin
                            done       = 1'b1;
                            pc_next    = pc;
                            state_next = IDLE;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the stimulus thread pushes the
// expected output vector for each cycle, a monitor pops and compares it.
module tb_instr_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] instr;
    logic [7:0] pc;
    logic [3:0] alu_op;
    logic       alu_flag_in;
    logic       alu_flag;
    logic [3:0] rf_raddr_b;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [1:0] rf_wsel;
    logic [7:0] imm;
    logic       busy;
    logic       done;

    logic [8:0] mem [0:255];

    typedef struct {
        string       name;
        logic [33:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    instr_sequencer #(.PC_W(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .start_addr(start_addr),
        .instr(instr),
        .pc(pc),
        .alu_op(alu_op),
        .alu_flag_in(alu_flag_in),
        .alu_flag(alu_flag),
        .rf_raddr_b(rf_raddr_b),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wsel(rf_wsel),
        .imm(imm),
        .busy(busy),
        .done(done)
    );

    assign instr = mem[pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field order: pc, alu_op, alu_flag_in, rf_raddr_b, rf_we, rf_waddr, rf_wsel, imm, busy, done
    function automatic logic [33:0] pk(input logic [7:0] p, input logic [3:0] op, input logic fi,
                                       input logic [3:0] rb, input logic we, input logic [3:0] wa,
                                       input logic [1:0] ws, input logic [7:0] im,
                                       input logic b, input logic d);
        return {p, op, fi, rb, we, wa, ws, im, b, d};
    endfunction

    function automatic logic [33:0] idl(input logic [7:0] p, input logic f);
        return pk(p, 4'd0, f, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0, 1'b0);
    endfunction

    function automatic logic [33:0] fet(input logic [7:0] p, input logic f);
        return pk(p, 4'd0, f, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b1, 1'b0);
    endfunction

    function automatic logic [33:0] exe(input logic [7:0] p, input logic f, input logic [3:0] op,
                                        input logic [3:0] rb, input logic we, input logic [3:0] wa,
                                        input logic [1:0] ws, input logic [7:0] im, input logic d);
        return pk(p, op, f, rb, we, wa, ws, im, 1'b1, d);
    endfunction

    task automatic chk(input string name, input logic [33:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t        e;
        logic [33:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = pk(pc, alu_op, alu_flag_in, rf_raddr_b, rf_we, rf_waddr, rf_wsel, imm, busy, done);
                checks++;
                if (got !== e.v) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h (pc,op,flag_in,rb,we,wa,wsel,imm,busy,done)",
                             e.name, got, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = 8'h00;
        alu_flag   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 9'h1E0;   // NOP
        mem[8'h10] = 9'h185;   // LI 5
        mem[8'h11] = 9'h063;   // ALU op6, rb=3
        mem[8'h12] = 9'h050;   // ALU op5 (flag only)
        mem[8'h13] = 9'h1A7;   // MOV r7
        mem[8'h14] = 9'h16D;   // BR -19 -> 0x01
        mem[8'h01] = 9'h17E;   // BR -2  -> 0xFF
        mem[8'hFF] = 9'h105;   // BR +5  -> 0x04 taken / 0x00 not taken
        mem[8'h04] = 9'h080;   // ALU op8 (flag only)
        mem[8'h05] = 9'h110;   // BR +16, not taken
        mem[8'h06] = 9'h080;   // ALU op8 (flag only)
        mem[8'h07] = 9'h119;   // BR +25 -> 0x20
        mem[8'h20] = 9'h1C0;   // HALT
        mem[8'h00] = 9'h061;   // ALU op6, rb=1

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("reset_idle", idl(8'h00, 1'b0));
        start = 1'b1; start_addr = 8'h10;
        chk("idle_start", idl(8'h00, 1'b0));
        start = 1'b0;
        chk("fetch_li", fet(8'h10, 1'b0));
        chk("exec_li", exe(8'h10, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 2'd1, 8'h05, 1'b0));
        chk("fetch_alu6", fet(8'h11, 1'b0));
        alu_flag = 1'b1;
        chk("exec_alu6", exe(8'h11, 1'b0, 4'd6, 4'd3, 1'b1, 4'd0, 2'd0, 8'h00, 1'b0));
        start = 1'b1; start_addr = 8'h40;
        chk("fetch_alu5_flag_in", fet(8'h12, 1'b1));
        chk("exec_alu5_no_we", exe(8'h12, 1'b1, 4'd5, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        start = 1'b0; alu_flag = 1'b0;
        chk("fetch_mov", fet(8'h13, 1'b1));
        chk("exec_mov", exe(8'h13, 1'b1, 4'd0, 4'd0, 1'b1, 4'd7, 2'd2, 8'h00, 1'b0));
        chk("fetch_br_back", fet(8'h14, 1'b1));
        chk("exec_br_back", exe(8'h14, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        chk("fetch_br_m2", fet(8'h01, 1'b1));
        chk("exec_br_m2", exe(8'h01, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        chk("fetch_wrap_ff", fet(8'hFF, 1'b1));
        chk("exec_br_ff_taken", exe(8'hFF, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        chk("fetch_04_wrap", fet(8'h04, 1'b1));
        alu_flag = 1'b0;
        chk("exec_alu8_clear", exe(8'h04, 1'b1, 4'd8, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        chk("fetch_05_flag0", fet(8'h05, 1'b0));
        chk("exec_br_not_taken", exe(8'h05, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        chk("fetch_06", fet(8'h06, 1'b0));
        alu_flag = 1'b1;
        chk("exec_alu8_set", exe(8'h06, 1'b0, 4'd8, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        alu_flag = 1'b0;
        chk("fetch_07", fet(8'h07, 1'b1));
        chk("exec_br_to_20", exe(8'h07, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        chk("fetch_halt", fet(8'h20, 1'b1));
        start = 1'b1; start_addr = 8'hFF;
        chk("exec_halt_done", exe(8'h20, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b1));
        chk("idle_after_halt", idl(8'h20, 1'b1));
        start = 1'b0;
        chk("fetch_ff_flag0", fet(8'hFF, 1'b0));
        chk("exec_br_ff_not_taken", exe(8'hFF, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 2'd0, 8'h00, 1'b0));
        chk("fetch_00_wrap", fet(8'h00, 1'b0));
        alu_flag = 1'b1; reset_n = 1'b0;
        chk("exec_alu_in_reset", exe(8'h00, 1'b0, 4'd6, 4'd1, 1'b1, 4'd0, 2'd0, 8'h00, 1'b0));
        reset_n = 1'b1; alu_flag = 1'b0;
        chk("post_reset_idle", idl(8'h00, 1'b0));
        chk("idle_hold", idl(8'h00, 1'b0));

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0 entries left", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001: Parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset_n  input  1  reset, synchronous, active-low.
REQ-004: start  input  1  begin execution at start_addr; honoured only in IDLE.
REQ-005: start_addr  input  PC_W  first instruction address.
REQ-006: instr  input  9  instruction-memory read data for address pc (combinational read).
REQ-007: pc  output  PC_W  registered instruction-memory address.
REQ-008: alu_op  output  4  ALU operation code.
REQ-009: alu_flag_in  output  1  registered flag, fed to the ALU flag input.
REQ-010: alu_flag  input  1  ALU flag result.
REQ-011: rf_raddr_b  output  4  register-file read address for ALU operand B; operand A is always r0.
REQ-012: rf_we  output  1  register-file write enable.
REQ-013: rf_waddr  output  4  register-file write address.
REQ-014: rf_wsel  output  2  write-data select: 0 = ALU out, 1 = imm, 2 = r0.
REQ-015: imm  output  8  immediate value.
REQ-016: busy  output  1  high in FETCH and EXEC.
REQ-017: done  output  1  one-cycle pulse when HALT executes.

Function
REQ-018: States are IDLE, FETCH and EXEC, with one instruction every 2 cycles.
REQ-019: IDLE with start=1 loads pc<=start_addr and flag_q<=0, then goes to FETCH.
REQ-020: FETCH latches instr into IR, then goes to EXEC.
REQ-021: EXEC decodes IR, updates pc and flag_q, then goes to FETCH, or to IDLE on HALT.
REQ-022: In IDLE and FETCH, alu_op, rf_we, rf_waddr, rf_raddr_b, rf_wsel, imm and done are all 0.
REQ-023: In EXEC, decode outputs are combinational from IR.
REQ-024: IR[8]=0 is ALU-type: alu_op=IR[7:4], rf_raddr_b=IR[3:0], rf_waddr=0, rf_wsel=0, flag_q<=alu_flag, pc<=pc+1.
REQ-025: ALU-type rf_we=1, except for alu_op 4'd5 and 4'd8 (flag-only), where rf_we=0.
REQ-026: IR[8:7]=2'b10 is BRANCH: if flag_q=1, pc<=pc+sign_extend(IR[6:0]); otherwise pc<=pc+1.
REQ-027: BRANCH sets rf_we=0 and leaves flag_q unchanged.
REQ-028: IR[8:5]=4'b1100 is LI: rf_we=1, rf_waddr=0, rf_wsel=1, imm={3'b0,IR[4:0]}, pc<=pc+1.
REQ-029: IR[8:5]=4'b1101 is MOV: rf_we=1, rf_waddr=IR[3:0], rf_wsel=2, pc<=pc+1.
REQ-030: IR[8:5]=4'b1110 is HALT: done=1 for that EXEC cycle, rf_we=0, pc unchanged, next state IDLE.
REQ-031: IR[8:5]=4'b1111 is NOP: pc<=pc+1 with no other effect.
REQ-032: All pc arithmetic is modulo 2^PC_W and wraps silently: pc+1 at max gives 0; branch offset -1 at pc=0 gives max.
REQ-033: alu_flag_in=flag_q at all times.
REQ-034: flag_q changes only on ALU-type EXEC and on start acceptance.
REQ-035: start asserted while busy=1 is ignored.
REQ-036: start asserted in the HALT EXEC cycle is ignored.
REQ-037: start is sampled in the following IDLE cycle.
REQ-038: A branch with offset 0 and flag_q=1 loops on itself; no detection is required.

Reset
REQ-039: When reset_n=0 at a clock edge, the next state is IDLE, with pc=0, IR=0 and flag_q=0.
REQ-040: After reset, busy=0 and done=0.
REQ-041: reset_n=0 overrides start and any in-flight instruction.
REQ-042: A reset in EXEC suppresses the pc and flag_q update of that cycle.
REQ-043: rf_we may be high combinationally during the reset cycle; the register file ignores writes while reset_n=0.

Verification
REQ-044: Reset, then start=1 with start_addr=8'h10, instr=LI 5 -> busy goes high; in EXEC: rf_we=1, rf_wsel=1, imm=8'h05; then pc=8'h11.
REQ-045: ALU op 4'd6 with IR[3:0]=3 and alu_flag=1 -> rf_raddr_b=3, rf_we=1, rf_waddr=0; next cycle alu_flag_in=1.
REQ-046: ALU op 4'd5 with alu_flag=1 -> rf_we=0; flag_q=1 then BRANCH offset 7'h7E at pc=8'h01 -> pc=8'hFF (wrap).
REQ-047: BRANCH with flag_q=0 at pc=8'hFF -> pc=8'h00.
REQ-048: HALT at pc=8'h20 -> done=1 for exactly one cycle; state IDLE, pc stays 8'h20, busy=0; start held high during HALT has no effect until the next IDLE cycle.
REQ-049: reset_n=0 in an EXEC of an ALU op with alu_flag=1 -> IDLE, pc=0, flag_q=0; start during busy mid-program leaves pc sequence unchanged.
